auth_resp_tx: RTL and testbench
===============================

Name: auth_resp_tx

Overview:
- Downstream stage of the authentication responder. Consumes the finished response (header, payload, bmRequestType, bRequest, wLength, current_timeout) when the responder raises resp_req_out.
- Serializes the response into a byte stream with a valid/ready handshake toward the USB control-endpoint data path.
- Returns a one-cycle acknowledge that drives the responder's Ack_in.
- Enforces the response timeout and rejects illegal lengths.

Parameters:
PAYLOAD_BYTES, 64, payload width in bytes; payload port is 8*PAYLOAD_BYTES bits.
HDR_BYTES, 4, header width in bytes (ProtocolVersion, MessageType, Param1, Param2).
CNT_W, 32, width of timeout counter and timeout_cycles.

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  response ready; connects to responder resp_req_out; level or pulse.
header  in  8*HDR_BYTES  response header; MSB byte = ProtocolVersion.
payload  in  8*PAYLOAD_BYTES  response payload; MSB byte sent first.
wlength  in  16  message byte count (header + payload bytes to send).
bm_request_type  in  8  USB bmRequestType.
b_request  in  8  USB bRequest.
timeout_cycles  in  CNT_W  abort limit in clk cycles; 0 = disabled.
tx_data  out  8  current byte.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at posedge.
tx_last  out  1  high with the final byte.
ack_out  out  1  one-cycle pulse after the final byte is accepted; drives responder Ack_in.
busy  out  1  high from the cycle after start is accepted until return to IDLE.
len_err  out  1  one-cycle pulse; length rejected.
timeout_err  out  1  one-cycle pulse; transfer aborted.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state = IDLE.
  - All outputs 0: tx_data, tx_valid, tx_last, ack_out, busy, len_err, timeout_err.
  - Counters cleared.
  - Reset mid-transfer: outputs are 0 on the cycle after the reset edge. No ack_out and no error pulse is generated.
- States: IDLE, CHECK, SEND, DONE, ABORT.
- IDLE:
  - start=1 at an edge latches all inputs into shadow registers and goes to CHECK.
  - Inputs are not resampled afterwards.
- CHECK (1 cycle, busy=1, tx_valid=0):
  - If wlength < HDR_BYTES or wlength > HDR_BYTES+PAYLOAD_BYTES: len_err=1 this cycle, next state IDLE.
  - Otherwise: total = wlength+4, byte index = 0, timeout counter = 0, next state SEND.
- SEND:
  - tx_valid=1. Byte stream in order:
    - idx0 = bm_request_type
    - idx1 = b_request
    - idx2 = wlength[7:0]
    - idx3 = wlength[15:8]
    - then wlength message bytes: header bytes MSB-first, then payload bytes MSB-first.
  - tx_last=1 when idx = total-1.
  - Index advances only on handshake. tx_data is stable while tx_valid && !tx_ready.
  - Payload bytes beyond wlength-HDR_BYTES are never sent.
  - Final-byte handshake goes to DONE.
- Timeout:
  - Counter increments every SEND cycle; saturates at all-ones.
  - If timeout_cycles != 0 and counter+1 == timeout_cycles at an edge without a final-byte handshake, go to ABORT.
  - A simultaneous final-byte handshake and timeout resolves to DONE (handshake wins).
- DONE (1 cycle): ack_out=1, tx_valid=0, busy=1; next state IDLE.
- ABORT (1 cycle): timeout_err=1, tx_valid=0, tx_last=0, busy=1; next state IDLE. ack_out is not asserted.
  - The sink treats a tx_valid drop without tx_last as transfer cancel.
- start while not in IDLE is ignored.
- start held high returns the block to CHECK on the edge after it leaves IDLE. The responder deasserts resp_req_out on ack_out.
- Latency (no back-pressure):
  - start sampled at edge E; CHECK in cycle E+1; first byte valid in cycle E+2.
  - Final handshake at edge F; ack_out in cycle F+1; busy=0 from cycle F+2.
- Widths: total computed in 17 bits; byte index 17 bits; no wrap possible given the length check.

Test Plan:
- Digest response: header=32'h01_01_00_00, wlength=36, payload MSB bytes 00..1F, tx_ready=1, timeout=0 -> 40 bytes: 80, 18, 24, 00, 01, 01, 00, 00, 00..1F; tx_last on byte 40; ack_out one cycle after; busy low 2 cycles after last handshake.
- Back-pressure: same message, tx_ready toggling 1,0,0,1,... -> identical byte sequence, tx_data stable during stalls, exactly one ack_out.
- Length errors: wlength=3 -> len_err pulse in cycle E+1, no tx_valid, no ack_out. wlength=HDR_BYTES+PAYLOAD_BYTES+1=69 -> same. wlength=4 -> 8 bytes, the last being the header LSB.
- Timeout: timeout_cycles=10, tx_ready=0 -> timeout_err pulse after 10 SEND cycles, tx_valid=0, no ack_out, back to IDLE. Final handshake on the 10th SEND cycle -> ack_out, no timeout_err.
- Reset mid-transfer: assert reset at byte 5 -> next cycle all outputs 0. New start after reset -> full clean stream from byte 0.
- Start during busy: pulse start with different header at byte 3 -> ignored; original bytes sent; single ack_out.

Source files
------------

// File: rtl/auth_resp_tx.sv
// Serializes a finished authentication response into a USB control-endpoint byte stream:
// a 4-byte setup prefix followed by wlength message bytes, with a length check and a response timeout.
module auth_resp_tx #(
   parameter int PAYLOAD_BYTES = 64,
   parameter int HDR_BYTES     = 4,
   parameter int CNT_W         = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [8*HDR_BYTES-1:0]     header,
   input  logic [8*PAYLOAD_BYTES-1:0] payload,
   input  logic [15:0]                wlength,
   input  logic [7:0]                 bm_request_type,
   input  logic [7:0]                 b_request,
   input  logic [CNT_W-1:0]           timeout_cycles,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       tx_last,
   output logic                       ack_out,
   output logic                       busy,
   output logic                       len_err,
   output logic                       timeout_err,
   output logic [2:0]                 dbg_state
);

   localparam int MSG_BYTES = HDR_BYTES + PAYLOAD_BYTES;
   localparam int MSG_W     = 8 * MSG_BYTES;
   localparam logic [15:0] LEN_MIN = 16'(HDR_BYTES);
   localparam logic [15:0] LEN_MAX = 16'(MSG_BYTES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_SEND  = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   // Shadow copies: the responder may change its outputs once the response is taken.
   logic [MSG_W-1:0] r_msg;
   logic [15:0]      r_wlength;
   logic [7:0]       r_bm;
   logic [7:0]       r_breq;
   logic [CNT_W-1:0] r_tmo;

   logic [16:0]      r_total;
   logic [16:0]      r_idx;
   logic [CNT_W-1:0] r_cnt;

   logic             w_len_bad;
   logic             w_hs;
   logic             w_last;
   logic             w_final_hs;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_tmo_hit;
   logic [16:0]      w_msg_off;
   logic [MSG_W-1:0] w_shifted;
   logic [7:0]       w_byte;

   assign w_len_bad  = (r_wlength < LEN_MIN) || (r_wlength > LEN_MAX);
   assign w_hs       = (r_state == S_SEND) && tx_ready;
   assign w_last     = (r_idx == (r_total - 17'd1));
   assign w_final_hs = w_hs && w_last;
   // One bit wider so a saturated counter can never alias onto a small limit.
   assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_tmo_hit  = (r_tmo != '0) && (w_cnt_inc == {1'b0, r_tmo});
   assign dbg_state  = r_state;

   always_comb begin
      w_msg_off = '0;
      if (r_idx >= 17'd4) w_msg_off = r_idx - 17'd4;
      w_shifted = r_msg << {w_msg_off, 3'b000};
      case (r_idx)
         17'd0:   w_byte = r_bm;
         17'd1:   w_byte = r_breq;
         17'd2:   w_byte = r_wlength[7:0];
         17'd3:   w_byte = r_wlength[15:8];
         default: w_byte = w_shifted[MSG_W-1 -: 8];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_msg     <= '0;
         r_wlength <= '0;
         r_bm      <= '0;
         r_breq    <= '0;
         r_tmo     <= '0;
         r_total   <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_msg     <= {header, payload};
                  r_wlength <= wlength;
                  r_bm      <= bm_request_type;
                  r_breq    <= b_request;
                  r_tmo     <= timeout_cycles;
               end
            end
            S_CHECK: begin
               r_total <= {1'b0, r_wlength} + 17'd4;
               r_idx   <= '0;
               r_cnt   <= '0;
            end
            S_SEND: begin
               if (w_hs) r_idx <= r_idx + 17'd1;
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      tx_data     = 8'h00;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      ack_out     = 1'b0;
      busy        = 1'b0;
      len_err     = 1'b0;
      timeout_err = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_CHECK;
         end
         S_CHECK: begin
            busy = 1'b1;
            if (w_len_bad) begin
               len_err = 1'b1;
               w_next  = S_IDLE;
            end else begin
               w_next = S_SEND;
            end
         end
         S_SEND: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = w_byte;
            tx_last  = w_last;
            // A final handshake on the limit cycle still completes the transfer.
            if (w_final_hs)     w_next = S_DONE;
            else if (w_tmo_hit) w_next = S_ABORT;
         end
         S_DONE: begin
            busy    = 1'b1;
            ack_out = 1'b1;
            w_next  = S_IDLE;
         end
         S_ABORT: begin
            busy        = 1'b1;
            timeout_err = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_auth_resp_tx.sv
// Bench for auth_resp_tx: vector table of transfers plus hand-written reset and stall sequences;
// a byte queue holds the expected stream and is popped on every handshake.
module tb_auth_resp_tx;

   localparam int PB = 64;
   localparam int HB = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [8*HB-1:0] header;
   logic [8*PB-1:0] payload;
   logic [15:0]     wlength;
   logic [7:0]      bm_request_type;
   logic [7:0]      b_request;
   logic [CW-1:0]   timeout_cycles;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            tx_last;
   logic            ack_out;
   logic            busy;
   logic            len_err;
   logic            timeout_err;
   logic [2:0]      dbg_state;

   auth_resp_tx #(.PAYLOAD_BYTES(PB), .HDR_BYTES(HB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .header(header), .payload(payload),
      .wlength(wlength), .bm_request_type(bm_request_type), .b_request(b_request),
      .timeout_cycles(timeout_cycles), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_last(tx_last), .ack_out(ack_out), .busy(busy),
      .len_err(len_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // mode: 0 ready always, 1 ready 1,0,0 repeating, 2 never ready, 3 random, 4 ready from 3rd SEND cycle
   typedef struct {
      logic [15:0] wl;
      int          mode;
      logic [31:0] tmo;
      int          glitch;
      int          exp_bytes;
      int          exp_ack;
      int          exp_len;
      int          exp_tmo;
   } vec_t;

   vec_t       vecs[11];
   logic [8:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;
   logic [2:0] idle_state;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_expected(input logic [15:0] wl, input logic [31:0] hdr);
      int n;
      int k;
      logic [7:0] b;
      n = int'(wl) + 4;
      for (int i = 0; i < n; i++) begin
         if (i == 0)      b = 8'h80;
         else if (i == 1) b = 8'h18;
         else if (i == 2) b = wl[7:0];
         else if (i == 3) b = wl[15:8];
         else begin
            k = i - 4;
            if (k < 4) b = hdr[31-8*k -: 8];
            else       b = payload[8*PB-1-8*(k-4) -: 8];
         end
         exp_q.push_back({(i == n - 1), b});
      end
   endtask

   task automatic apply_vec(input vec_t v);
      int nb, na, nl, nt, ack_c, hs_c, tmo_c, len_c, end_c;
      logic [7:0] prev_d;
      logic       prev_stall;
      logic       glitched;
      logic       done;
      logic [8:0] e;
      nb = 0; na = 0; nl = 0; nt = 0;
      ack_c = -1; hs_c = -1; tmo_c = -1; len_c = -1; end_c = -1;
      prev_d = '0; prev_stall = 1'b0; glitched = 1'b0; done = 1'b0;
      exp_q.delete();
      header = 32'h01_01_00_00;
      wlength = v.wl;
      timeout_cycles = v.tmo;
      if (v.wl >= 16'd4 && v.wl <= 16'd68) push_expected(v.wl, header);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         case (v.mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (cyc > 0) && (((cyc - 1) % 3) == 0);
            2: tx_ready = 1'b0;
            3: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = (cyc >= 3);
         endcase
         if (v.glitch >= 0 && nb == v.glitch && !glitched) begin
            start = 1'b1;
            header = 32'hDEAD_BEEF;
            glitched = 1'b1;
         end else begin
            start = 1'b0;
         end
         #1;
         if (cyc == 0) check("check_cycle", {busy, tx_valid}, 2'b10);
         if (ack_out) begin na++; ack_c = cyc; end
         if (len_err) begin nl++; len_c = cyc; end
         if (timeout_err) begin
            nt++; tmo_c = cyc;
            check("abort_outputs", {tx_valid, tx_last, ack_out}, 3'b000);
         end
         if (!tx_valid) check("idle_last", tx_last, 1'b0);
         if (prev_stall && tx_valid) check("stall_hold", tx_data, prev_d);
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", {tx_last, tx_data}, 9'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("byte", {tx_last, tx_data}, e);
            end
            nb++;
            hs_c = cyc;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_d = tx_data;
         if (!busy) begin
            end_c = cyc;
            done = 1'b1;
            break;
         end
      end
      if (!done) check("busy_bound", 1'b0, 1'b1);
      check("n_bytes", nb, v.exp_bytes);
      check("n_ack", na, v.exp_ack);
      check("n_len_err", nl, v.exp_len);
      check("n_timeout", nt, v.exp_tmo);
      if (v.exp_ack != 0) begin
         check("ack_latency", ack_c, hs_c + 1);
         check("idle_latency", end_c, hs_c + 2);
      end
      if (v.exp_tmo != 0) check("timeout_cycle", tmo_c, int'(v.tmo) + 1);
      if (v.exp_len != 0) check("len_err_cycle", len_c, 0);
      start = 1'b0;
      tx_ready = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int nb;
      logic [8:0] e;
      vecs[0]  = '{16'd36, 0, 32'd0,  -1, 40, 1, 0, 0};
      vecs[1]  = '{16'd36, 1, 32'd0,  -1, 40, 1, 0, 0};
      vecs[2]  = '{16'd3,  0, 32'd0,  -1, 0,  0, 1, 0};
      vecs[3]  = '{16'd69, 0, 32'd0,  -1, 0,  0, 1, 0};
      vecs[4]  = '{16'd4,  0, 32'd0,  -1, 8,  1, 0, 0};
      vecs[5]  = '{16'd36, 2, 32'd10, -1, 0,  0, 0, 1};
      vecs[6]  = '{16'd4,  4, 32'd10, -1, 8,  1, 0, 0};
      vecs[7]  = '{16'd4,  4, 32'd9,  -1, 7,  0, 0, 1};
      vecs[8]  = '{16'd36, 0, 32'd0,  3,  40, 1, 0, 0};
      vecs[9]  = '{16'd68, 3, 32'd0,  -1, 72, 1, 0, 0};
      vecs[10] = '{16'd0,  0, 32'd0,  -1, 0,  0, 1, 0};

      for (int k = 0; k < PB; k++) payload[8*PB-1-8*k -: 8] = 8'(k);
      reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
      header = 32'h01_01_00_00; wlength = 16'd36;
      bm_request_type = 8'h80; b_request = 8'h18; timeout_cycles = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {tx_data, tx_valid, tx_last, ack_out, busy, len_err, timeout_err}, 14'h0);
      idle_state = dbg_state;
      reset = 1'b0;

      for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

      // Reset while byte 5 is on the bus.
      exp_q.delete();
      wlength = 16'd36; timeout_cycles = '0; header = 32'h01_01_00_00;
      push_expected(16'd36, header);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tx_ready = 1'b1;
      nb = 0;
      for (int cyc = 0; cyc < 200 && nb < 5; cyc++) begin
         @(posedge clk); #1;
         if (tx_valid && tx_ready) begin
            e = exp_q.pop_front();
            check("pre_reset_byte", {tx_last, tx_data}, e);
            nb++;
         end
      end
      check("pre_reset_count", nb, 5);
      check("byte5_presented", {tx_valid, tx_data}, {1'b1, 8'h01});
      reset = 1'b1;
      @(posedge clk); #1;
      check("reset_mid_outputs", {tx_data, tx_valid, tx_last, ack_out, busy, len_err, timeout_err}, 14'h0);
      check("reset_mid_state", dbg_state, idle_state);
      reset = 1'b0;
      tx_ready = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(posedge clk); #1;
         check("post_reset_quiet", {ack_out, len_err, timeout_err, busy}, 4'h0);
      end
      apply_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
